pixel_timing_gen: RTL and testbench

- Video timing generator running in the pixel clock domain, fed by the 65 MHz pixel PLL output.
- Produces hsync, vsync, data-enable and pixel counters for 1024x768@60 (XGA) by default.
- Pulls pixels from an upstream stream (valid/ready) during the active region and presents them to the display interface.
- Held idle until the PLL reports lock; returns to idle when lock is lost.

---
 rtl/pixel_timing_gen.sv | 166 ++++++++++++++++
 tb/tb_pixel_timing_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_timing_gen.sv
// Video timing generator for the pixel clock domain: sync/DE/counter generation
// with a two-stage registered output pipeline and a valid/ready pixel pull.
module pixel_timing_gen #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   DATA_W   = 24
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pll_locked,
    input  logic              enable,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [DATA_W-1:0] pix_data,
    output logic [10:0]       h_count,
    output logic [9:0]        v_count,
    output logic              sof,
    output logic              underflow,
    input  logic              underflow_clr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic in_win(input int pos, input int lo, input int hi);
        return (pos >= lo) && (pos < hi);
    endfunction

    state_t              state_q, state_d;
    logic                lock_s1_q, lock_s1_d;
    logic                lock_s2_q, lock_s2_d;
    logic [10:0]         h_cnt_q, h_cnt_d;
    logic [9:0]          v_cnt_q, v_cnt_d;
    logic                de_p1_q, de_p1_d;
    logic                hs_p1_q, hs_p1_d;
    logic                vs_p1_q, vs_p1_d;
    logic                sof_p1_q, sof_p1_d;
    logic                hsync_p2_q, hsync_p2_d;
    logic                vsync_p2_q, vsync_p2_d;
    logic                de_p2_q, de_p2_d;
    logic                sof_p2_q, sof_p2_d;
    logic [DATA_W-1:0]   pix_p2_q, pix_p2_d;
    logic [10:0]         h_count_p2_q, h_count_p2_d;
    logic [9:0]          v_count_p2_q, v_count_p2_d;
    logic                underflow_q, underflow_d;
    logic                run_d;
    logic                go;
    logic                vld_p1;
    logic                xfer;

    always_comb begin
        lock_s1_d = pll_locked;
        lock_s2_d = lock_s1_q;
        state_d   = state_q;
        case (state_q)
            IDLE:    if (enable && lock_s2_q) state_d = RUN;
            RUN:     if (!(enable && lock_s2_q)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        run_d  = (state_d == RUN);
        go     = (state_q == IDLE) && run_d;
        vld_p1 = (state_q == RUN);

        // stage 1: counters describe the pixel whose decode lands in the _p1 flops
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (run_d && !go) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
                v_cnt_d = v_cnt_q;
            end
        end
        de_p1_d  = run_d && in_win(int'(h_cnt_d), 0, H_ACTIVE)
                         && in_win(int'(v_cnt_d), 0, V_ACTIVE);
        hs_p1_d  = run_d && in_win(int'(h_cnt_d), HS_START, HS_START + H_SYNC);
        vs_p1_d  = run_d && in_win(int'(v_cnt_d), VS_START, VS_START + V_SYNC);
        sof_p1_d = run_d && (h_cnt_d == '0) && (v_cnt_d == '0);

        // stage 2: pixel captured here, so every display output is delayed to match it
        xfer         = s_valid && de_p1_q;
        de_p2_d      = run_d && vld_p1 && de_p1_q;
        sof_p2_d     = run_d && vld_p1 && sof_p1_q;
        hsync_p2_d   = (run_d && vld_p1 && hs_p1_q) ? HS_POL : ~HS_POL;
        vsync_p2_d   = (run_d && vld_p1 && vs_p1_q) ? VS_POL : ~VS_POL;
        pix_p2_d     = (run_d && xfer) ? s_data : '0;
        h_count_p2_d = run_d ? h_cnt_q : '0;
        v_count_p2_d = run_d ? v_cnt_q : '0;

        // a fresh underflow outranks a simultaneous clear
        if (de_p1_q && !s_valid)  underflow_d = 1'b1;
        else if (underflow_clr)   underflow_d = 1'b0;
        else                      underflow_d = underflow_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            lock_s1_q    <= 1'b0;
            lock_s2_q    <= 1'b0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            de_p1_q      <= 1'b0;
            hs_p1_q      <= 1'b0;
            vs_p1_q      <= 1'b0;
            sof_p1_q     <= 1'b0;
            hsync_p2_q   <= ~HS_POL;
            vsync_p2_q   <= ~VS_POL;
            de_p2_q      <= 1'b0;
            sof_p2_q     <= 1'b0;
            pix_p2_q     <= '0;
            h_count_p2_q <= '0;
            v_count_p2_q <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_s1_q    <= lock_s1_d;
            lock_s2_q    <= lock_s2_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            de_p1_q      <= de_p1_d;
            hs_p1_q      <= hs_p1_d;
            vs_p1_q      <= vs_p1_d;
            sof_p1_q     <= sof_p1_d;
            hsync_p2_q   <= hsync_p2_d;
            vsync_p2_q   <= vsync_p2_d;
            de_p2_q      <= de_p2_d;
            sof_p2_q     <= sof_p2_d;
            pix_p2_q     <= pix_p2_d;
            h_count_p2_q <= h_count_p2_d;
            v_count_p2_q <= v_count_p2_d;
            underflow_q  <= underflow_d;
        end
    end

    assign s_ready   = de_p1_q;
    assign hsync     = hsync_p2_q;
    assign vsync     = vsync_p2_q;
    assign de        = de_p2_q;
    assign sof       = sof_p2_q;
    assign pix_data  = pix_p2_q;
    assign h_count   = h_count_p2_q;
    assign v_count   = v_count_p2_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Scoreboard bench for pixel_timing_gen on a reduced 25x10 raster; a frame-position
// reference model predicts every output cycle and a monitor compares them.
module tb_pixel_timing_gen;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          pll_locked = 1'b0;
    logic          enable = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          hsync, vsync, de, sof, underflow;
    logic          underflow_clr = 1'b0;
    logic [DW-1:0] pix_data;
    logic [10:0]   h_count;
    logic [9:0]    v_count;

    int n_checks = 0;
    int n_fail   = 0;

    pixel_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(DW)
    ) dut (
        .clk(clk), .resetn(resetn), .pll_locked(pll_locked), .enable(enable),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .hsync(hsync), .vsync(vsync), .de(de), .pix_data(pix_data),
        .h_count(h_count), .v_count(v_count), .sof(sof),
        .underflow(underflow), .underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hs, vs, de, sof, rdy, uf;
        logic [DW-1:0] pix;
        int            h, v;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic pos_de(input int p);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        return (h < HA) && (v < VA);
    endfunction

    // age = edges since the generator left idle; outputs trail the counters by one
    int   m_age = 0;
    logic m_l1 = 0, m_l2 = 0, m_uf = 0;

    always @(posedge clk) begin
        exp_t e;
        logic ls, de1;
        logic [DW-1:0] px;
        int p, h, v;
        e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, sof: 1'b0, rdy: 1'b0, uf: 1'b0, pix: '0, h: 0, v: 0};
        if (!resetn) begin
            m_age = 0; m_l1 = 0; m_l2 = 0; m_uf = 0;
        end else begin
            de1 = (m_age >= 1) && pos_de(m_age - 1);
            if (de1 && !s_valid)     m_uf = 1'b1;
            else if (underflow_clr)  m_uf = 1'b0;
            px = (de1 && s_valid) ? s_data : '0;
            ls = m_l2; m_l2 = m_l1; m_l1 = pll_locked;
            m_age = (enable && ls) ? m_age + 1 : 0;
            if (m_age >= 2) begin
                p = m_age - 2;
                h = p % HT;
                v = (p / HT) % VT;
                e.h   = h;
                e.v   = v;
                e.de  = (h < HA) && (v < VA);
                e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
                e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
                e.sof = (h == 0) && (v == 0);
                e.pix = px;
            end
            e.rdy = (m_age >= 1) && pos_de(m_age - 1);
            e.uf  = m_uf;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (hsync !== e.hs || vsync !== e.vs || de !== e.de || sof !== e.sof ||
                s_ready !== e.rdy || underflow !== e.uf || pix_data !== e.pix ||
                int'(h_count) != e.h || int'(v_count) != e.v) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got h=%0d v=%0d hs=%b vs=%b de=%b sof=%b rdy=%b uf=%b pix=%h expected h=%0d v=%0d hs=%b vs=%b de=%b sof=%b rdy=%b uf=%b pix=%h",
                         $time, h_count, v_count, hsync, vsync, de, sof, s_ready, underflow, pix_data,
                         e.h, e.v, e.hs, e.vs, e.de, e.sof, e.rdy, e.uf, e.pix);
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int  k = 0;
    bit  pat_mode = 0;
    bit  rnd_mode = 0;

    task automatic step();
        @(negedge clk);
        if (pat_mode) begin
            s_valid = 1'b1;
            s_data  = DW'(k);
            if (s_ready) k++;
        end else if (rnd_mode) begin
            s_valid       = ($urandom_range(9) != 0);
            s_data        = DW'($urandom);
            underflow_clr = ($urandom_range(7) == 0);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, longint'({hsync, vsync, de, sof, s_ready, h_count, v_count, pix_data}),
              longint'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 10'd0, {DW{1'b0}}}));
    endtask

    task automatic measure_start(input string name);
        int n;
        n = 0;
        do begin step(); n++; end while (!sof && n < 20);
        check(name, n, 4);
    endtask

    task automatic wait_pos(input int h, input int v, input string name);
        int n;
        n = 0;
        while (!(int'(h_count) == h && int'(v_count) == v) && n < 2 * FRAME) begin
            step(); n++;
        end
        if (n >= 2 * FRAME) check(name, 0, 1);
    endtask

    task automatic frame_stats();
        int n, period, des, xf;
        n = 0;
        while (!sof && n < 2 * FRAME) begin step(); n++; end
        period = 0; des = 0; xf = 0;
        do begin
            if (de) des++;
            if (s_valid && s_ready) xf++;
            step();
            period++;
        end while (!sof && period < 2 * FRAME);
        check("sof_period", period, FRAME);
        check("de_per_frame", des, HA * VA);
        check("xfer_per_frame", xf, HA * VA);
    endtask

    initial begin
        repeat (3) step();
        check_idle("reset_outputs");
        check("reset_underflow", underflow, 0);
        resetn = 1'b1;
        repeat (3) step();
        check_idle("idle_no_lock");

        enable = 1'b1; pll_locked = 1'b1; pat_mode = 1;
        measure_start("start_latency");
        frame_stats();
        frame_stats();

        pat_mode = 0; rnd_mode = 1;
        repeat (2 * FRAME) step();
        rnd_mode = 0;
        s_valid = 1'b1; underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        step();
        check("underflow_cleared", underflow, 0);

        wait_pos(4, 2, "wait_underflow_pos");
        s_valid = 1'b0;
        repeat (5) step();
        s_valid = 1'b1;
        step();
        check("underflow_set", underflow, 1);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        check("underflow_clr", underflow, 0);
        while (!s_ready) step();
        s_valid = 1'b0; underflow_clr = 1'b1;
        step();
        s_valid = 1'b1; underflow_clr = 1'b0;
        check("underflow_set_wins", underflow, 1);

        wait_pos(10, 4, "wait_lock_pos");
        pll_locked = 1'b0;
        repeat (4) step();
        check_idle("lock_lost_idle");
        pll_locked = 1'b1;
        measure_start("relock_latency");
        repeat (FRAME / 2) step();

        enable = 1'b0;
        step();
        check_idle("disable_idle");
        enable = 1'b1;
        rnd_mode = 1;
        repeat (FRAME) step();
        rnd_mode = 0; s_valid = 1'b1; underflow_clr = 1'b0;

        wait_pos(7, 1, "wait_reset_pos");
        resetn = 1'b0;
        step();
        check_idle("midline_reset");
        check("midline_reset_uf", underflow, 0);
        resetn = 1'b1;
        pat_mode = 1;
        measure_start("reset_restart_latency");
        frame_stats();
        pat_mode = 0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
